// File: rtl/pe_pkg.sv
// Shared definitions for the PE feeder: PE mode encodings, feeder state enum, default data width.
package pe_pkg;

   localparam int PE_DW = 8;

   localparam logic [1:0] MODE_CONV = 2'd0;
   localparam logic [1:0] MODE_ALT  = 2'd1;
   localparam logic [1:0] MODE_LOAD = 2'd2;
   localparam logic [1:0] MODE_IDLE = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } feed_state_t;

endpackage

// File: rtl/pe_feed_buf.sv
// Host-loaded tap and stream storage for the PE feeder: one write port, combinational reads by index.
module pe_feed_buf
   import pe_pkg::*;
#(
   parameter  int DW    = PE_DW,
   parameter  int KTAPS = 3,
   parameter  int NMAX  = 16,
   localparam int AW    = $clog2(NMAX),
   localparam int TW    = (KTAPS > 1) ? $clog2(KTAPS) : 1
) (
   input  logic            clk,
   input  logic            we,
   input  logic            sel,
   input  logic [AW-1:0]   addr,
   input  logic [2*DW-1:0] data,
   input  logic [TW-1:0]   tap_idx,
   input  logic [AW-1:0]   str_idx,
   output logic [DW-1:0]   tap_rd,
   output logic [2*DW-1:0] str_rd
);

   logic [DW-1:0]   tap_mem [KTAPS];
   logic [2*DW-1:0] str_mem [NMAX];

   // Contents survive reset on purpose: the host preloads once and may re-run many times.
   always_ff @(posedge clk) begin
      if (we) begin
         if (!sel) begin
            if (int'(addr[TW-1:0]) < KTAPS) tap_mem[addr[TW-1:0]] <= data[DW-1:0];
         end else if (int'(addr) < NMAX) begin
            str_mem[addr] <= data;
         end
      end
   end

   assign tap_rd = (int'(tap_idx) < KTAPS) ? tap_mem[tap_idx] : '0;
   assign str_rd = (int'(str_idx) < NMAX)  ? str_mem[str_idx] : '0;

endmodule

// File: rtl/pe_feeder.sv
// Transmit side of the PE input protocol: ACT -> LOAD -> STREAM -> DRAIN -> DONE, then capture pe_out.
// Optional feature macro: PE_FEED_SKIP_LOAD_EN adds skip_load (bypass the LOAD phase).
module pe_feeder
   import pe_pkg::*;
#(
   parameter  int DW     = PE_DW,
   parameter  int KTAPS  = 3,
   parameter  int NMAX   = 16,
   parameter  int PE_LAT = 1,
   localparam int AW     = $clog2(NMAX)
) (
   input  logic            clk,
   input  logic            rst,
`ifdef PE_FEED_SKIP_LOAD_EN
   input  logic            skip_load,
`endif
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [AW-1:0]   wr_addr,
   input  logic [2*DW-1:0] wr_data,
   input  logic            start,
   input  logic            op_sel,
   input  logic [AW:0]     cfg_len,
   output logic            busy,
   output logic            done,
   output logic            wr_drop,
   output logic [DW-1:0]   pe_in,
   output logic [DW-1:0]   pe_filter,
   output logic [1:0]      mode_o,
   output logic            activate,
   input  logic [DW-1:0]   pe_out,
   output logic [DW-1:0]   res_data,
   output logic            res_valid
);

   localparam int CW = AW + 1;
   localparam int TW = (KTAPS > 1) ? $clog2(KTAPS) : 1;
   localparam logic [CW-1:0] NMAX_C = CW'(NMAX);
   localparam logic [CW-1:0] KLAST  = CW'(KTAPS - 1);
   localparam logic [CW-1:0] DLAST  = CW'(PE_LAT - 1);

   feed_state_t     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, len_q, len_d;
   logic            op_q, op_d, skip_q, skip_d;
   logic [DW-1:0]   tap_rd;
   logic [2*DW-1:0] str_rd;

   pe_feed_buf #(.DW(DW), .KTAPS(KTAPS), .NMAX(NMAX)) u_buf (
      .clk     (clk),
      .we      (wr_en && !busy),
      .sel     (wr_sel),
      .addr    (wr_addr),
      .data    (wr_data),
      .tap_idx (cnt_d[TW-1:0]),
      .str_idx (cnt_d[AW-1:0]),
      .tap_rd  (tap_rd),
      .str_rd  (str_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         op_q    <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         op_q    <= op_d;
         skip_q  <= skip_d;
      end
   end

   // cnt is the cycle index inside the current phase; each phase exits on its terminal count,
   // so the counter never increments past it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      op_d    = op_q;
      skip_d  = skip_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACT;
               cnt_d   = '0;
               op_d    = op_sel;
               len_d   = (cfg_len > NMAX_C) ? NMAX_C : cfg_len;
`ifdef PE_FEED_SKIP_LOAD_EN
               skip_d  = skip_load;
`else
               skip_d  = 1'b0;
`endif
            end
         end
         S_ACT: begin
            cnt_d = '0;
            if (!skip_q)           state_d = S_LOAD;
            else if (len_q == '0)  state_d = S_DRAIN;
            else                   state_d = S_STREAM;
         end
         S_LOAD: begin
            if (cnt_q == KLAST) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? S_DRAIN : S_STREAM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (cnt_q == len_q - 1'b1) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DLAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // PE-side outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_drop   <= 1'b0;
         pe_in     <= '0;
         pe_filter <= '0;
         mode_o    <= MODE_IDLE;
         activate  <= 1'b0;
         res_data  <= '0;
         res_valid <= 1'b0;
      end else begin
         busy      <= (state_d != S_IDLE);
         activate  <= (state_d != S_IDLE);
         done      <= (state_d == S_DONE);
         res_valid <= (state_d == S_DONE);
         wr_drop   <= wr_en && busy;
         mode_o    <= MODE_IDLE;
         pe_in     <= '0;
         pe_filter <= '0;
         case (state_d)
            S_LOAD: begin
               mode_o    <= MODE_LOAD;
               pe_filter <= tap_rd;
            end
            S_STREAM: begin
               mode_o    <= op_q ? MODE_ALT : MODE_CONV;
               pe_filter <= str_rd[2*DW-1:DW];
               pe_in     <= str_rd[DW-1:0];
            end
            default: ;
         endcase
         if (state_q == S_DRAIN && state_d == S_DONE) res_data <= pe_out;
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: table of scenarios checked cycle by cycle plus abort/drop sequences.
module tb_pe_feeder;

   localparam int DW = 8, KTAPS = 3, NMAX = 16, PE_LAT = 1, AW = 4;

   logic            clk = 1'b0, rst = 1'b0;
   logic            wr_en = 1'b0, wr_sel = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [2*DW-1:0] wr_data = '0;
   logic            start = 1'b0, op_sel = 1'b0;
   logic [AW:0]     cfg_len = '0;
   logic            busy, done, wr_drop, activate, res_valid;
   logic [DW-1:0]   pe_in, pe_filter, res_data;
   logic [1:0]      mode_o;
   logic [DW-1:0]   pe_out = '0;
`ifdef PE_FEED_SKIP_LOAD_EN
   logic            skip_load = 1'b0;
`endif

   pe_feeder #(.DW(DW), .KTAPS(KTAPS), .NMAX(NMAX), .PE_LAT(PE_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef PE_FEED_SKIP_LOAD_EN
      .skip_load (skip_load),
`endif
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .op_sel    (op_sel),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .done      (done),
      .wr_drop   (wr_drop),
      .pe_in     (pe_in),
      .pe_filter (pe_filter),
      .mode_o    (mode_o),
      .activate  (activate),
      .pe_out    (pe_out),
      .res_data  (res_data),
      .res_valid (res_valid)
   );

   always #5 clk = ~clk;

   // Stand-in PE result: changes every cycle so a mistimed capture shows up.
   always @(posedge clk) pe_out <= pe_out + 8'd7;

   typedef struct {
      int tap_base;
      int op;
      int cfg_len;
      int exp_busy;
      int exp_strm;
   } vec_t;

   vec_t          tbl[5];
   int            n_vec = 0, n_err = 0;
   logic [DW-1:0] tap_m [KTAPS];
   logic [DW-1:0] s_in  [NMAX];
   logic [DW-1:0] s_f   [NMAX];
   logic [DW-1:0] last_res = '0;
   int            nb, ns;

   function automatic logic [31:0] obs();
      return {1'b0, mode_o, busy, activate, done, res_valid, wr_drop, pe_in, pe_filter, res_data};
   endfunction

   function automatic logic [31:0] pack(logic [1:0] m, logic b, logic dn, logic wd,
                                        logic [7:0] i, logic [7:0] f, logic [7:0] r);
      return {1'b0, m, b, b, dn, dn, wd, i, f, r};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic sel, input int addr, input int data);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = 16'(data);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // inj 0: plain run; 1: write+start while busy, start again in DONE; 2: reset during STREAM.
   task automatic run_seq(input int tap_base, input int op, input int clen, input int inj,
                          output int nbusy, output int nstrm);
      int            len_e, cyc;
      logic          dn;
      logic [1:0]    m;
      logic [7:0]    ei, ef, er, pe_prev;
      len_e = (clen > NMAX) ? NMAX : clen;
      nbusy = 0; nstrm = 0; pe_prev = '0;
      wr(1'b0, 0, tap_base);     tap_m[0] = 8'(tap_base);
      wr(1'b0, 1, tap_base + 1); tap_m[1] = 8'(tap_base + 1);
      // last tap write shares the edge with start
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd2; wr_data = 16'(tap_base + 2);
      tap_m[2] = 8'(tap_base + 2);
      start = 1'b1; op_sel = op[0]; cfg_len = 5'(clen);
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      for (cyc = 0; cyc < 60; cyc++) begin
         if (!busy) break;
         nbusy++;
         if (mode_o < 2'd2) nstrm++;
         if (cyc <= 1 + KTAPS + len_e + PE_LAT) begin
            dn = (cyc == 1 + KTAPS + len_e + PE_LAT);
            m = 2'd3; ei = '0; ef = '0;
            if (cyc >= 1 && cyc <= KTAPS) begin
               m = 2'd2; ef = tap_m[cyc-1];
            end else if (cyc > KTAPS && cyc <= KTAPS + len_e) begin
               m = {1'b0, op[0]}; ei = s_in[cyc-1-KTAPS]; ef = s_f[cyc-1-KTAPS];
            end
            er = dn ? pe_prev : last_res;
            chk($sformatf("cyc%0d", cyc), obs(), pack(m, 1'b1, dn, (inj == 1 && cyc == 4), ei, ef, er));
            if (dn) last_res = pe_prev;
         end
         pe_prev = pe_out;
         if (inj == 1 && cyc == 3) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = 16'hFFFF; start = 1'b1;
         end
         if (inj == 1 && cyc == 4) begin
            wr_en = 1'b0; start = 1'b0;
         end
         if (inj == 1 && cyc == 1 + KTAPS + len_e + PE_LAT) start = 1'b1;
         if (inj == 2 && cyc == 6) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            last_res = '0;
            chk("abort", obs(), pack(2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (cyc >= 60) chk("timeout", 32'(cyc), 32'd0);
      chk("idle0", obs(), pack(2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, last_res));
      @(negedge clk);
      chk("idle1", obs(), pack(2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, last_res));
   endtask

   initial begin
      tbl[0] = '{tap_base: 1,  op: 0, cfg_len: 10, exp_busy: 16, exp_strm: 10};
      tbl[1] = '{tap_base: 10, op: 1, cfg_len: 6,  exp_busy: 12, exp_strm: 6};
      tbl[2] = '{tap_base: 1,  op: 0, cfg_len: 0,  exp_busy: 6,  exp_strm: 0};
      tbl[3] = '{tap_base: 1,  op: 1, cfg_len: 31, exp_busy: 22, exp_strm: 16};
      tbl[4] = '{tap_base: 5,  op: 0, cfg_len: 16, exp_busy: 22, exp_strm: 16};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset", obs(), pack(2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
      rst = 1'b1;

      for (int j = 0; j < NMAX; j++) begin
         wr(1'b1, j, {8'(j + 2), 8'(j + 1)});
         s_in[j] = 8'(j + 1);
         s_f[j]  = 8'(j + 2);
      end

      for (int v = 0; v < 5; v++) begin
         run_seq(tbl[v].tap_base, tbl[v].op, tbl[v].cfg_len, 0, nb, ns);
         chk($sformatf("busy_len%0d", v), 32'(nb), 32'(tbl[v].exp_busy));
         chk($sformatf("strm_len%0d", v), 32'(ns), 32'(tbl[v].exp_strm));
      end

      // dropped write + ignored starts, then rerun proves the buffer kept its contents
      run_seq(1, 0, 10, 1, nb, ns);
      chk("busy_drop", 32'(nb), 32'd16);
      run_seq(1, 0, 10, 0, nb, ns);
      chk("busy_rerun", 32'(nb), 32'd16);

      // reset mid-stream, then restart reproduces the conv run
      run_seq(1, 0, 10, 2, nb, ns);
      run_seq(1, 0, 10, 0, nb, ns);
      chk("busy_restart", 32'(nb), 32'd16);
      chk("strm_restart", 32'(ns), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
